// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus: fetch-side inputs and decode-side outputs of if_id_stage.
// Optional IF_ID_PERF_EN adds the saturating performance counter outputs.
interface if_id_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] instr_in;
  logic [DATA_W-1:0] pc_plus_1_in;
  logic              stall;
  logic              flush;
  logic              hlt_retired;
  logic [DATA_W-1:0] instr_out;
  logic [DATA_W-1:0] pc_plus_1_out;
  logic              valid_out;
  logic              hlt_fetch;
  logic              halted;
`ifdef IF_ID_PERF_EN
  logic [15:0]       perf_fetch;
  logic [15:0]       perf_bubble;
  logic [15:0]       perf_stall;

  modport master (
    output instr_in, pc_plus_1_in, stall, flush, hlt_retired,
    input  instr_out, pc_plus_1_out, valid_out, hlt_fetch, halted,
    input  perf_fetch, perf_bubble, perf_stall
  );
  modport slave (
    input  instr_in, pc_plus_1_in, stall, flush, hlt_retired,
    output instr_out, pc_plus_1_out, valid_out, hlt_fetch, halted,
    output perf_fetch, perf_bubble, perf_stall
  );
`else
  modport master (
    output instr_in, pc_plus_1_in, stall, flush, hlt_retired,
    input  instr_out, pc_plus_1_out, valid_out, hlt_fetch, halted
  );
  modport slave (
    input  instr_in, pc_plus_1_in, stall, flush, hlt_retired,
    output instr_out, pc_plus_1_out, valid_out, hlt_fetch, halted
  );
`endif
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall, flush and HLT sequencing (RUN -> HALT_PEND -> HALTED).
// Define IF_ID_PERF_EN to add saturating fetch/bubble/stall counters.
module if_id_stage #(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] NOP_INSTR  = '0,
  parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t            state;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_p1;
  logic              vld_p1;
  logic              hlt_fetch_q;
  logic              halted_q;
  logic              is_hlt;

  assign is_hlt = (bus.instr_in[DATA_W-1:DATA_W-4] == HLT_OPCODE);

  // Fetch -> decode stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      instr_p1    <= NOP_INSTR;
      pc_p1       <= '0;
      vld_p1      <= 1'b0;
      hlt_fetch_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.flush) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end else if (!bus.stall) begin
            instr_p1 <= bus.instr_in;
            pc_p1    <= bus.pc_plus_1_in;
            vld_p1   <= 1'b1;
            if (is_hlt) begin
              state       <= HALT_PEND;
              hlt_fetch_q <= 1'b1;
            end
          end
        end
        HALT_PEND: begin
          // Retirement overrides both stall and flush: the HLT has committed.
          if (bus.hlt_retired) begin
            state    <= HALTED;
            halted_q <= 1'b1;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end else if (bus.flush) begin
            state       <= RUN;
            hlt_fetch_q <= 1'b0;
            instr_p1    <= NOP_INSTR;
            vld_p1      <= 1'b0;
          end else if (!bus.stall) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.instr_out     = instr_p1;
  assign bus.pc_plus_1_out = pc_p1;
  assign bus.valid_out     = vld_p1;
  assign bus.hlt_fetch     = hlt_fetch_q;
  assign bus.halted        = halted_q;

`ifdef IF_ID_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
  logic [15:0] stall_cnt;
  logic        ev_fetch;
  logic        ev_bubble;
  logic        ev_stall;

  assign ev_fetch  = (state == RUN) && !bus.flush && !bus.stall;
  assign ev_bubble = (state != HALTED) &&
                     (bus.flush || ((state == HALT_PEND) && !bus.stall));
  assign ev_stall  = (state == RUN) && bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (ev_fetch)  fetch_cnt  <= sat_inc(fetch_cnt);
      if (ev_bubble) bubble_cnt <= sat_inc(bubble_cnt);
      if (ev_stall)  stall_cnt  <= sat_inc(stall_cnt);
    end
  end

  assign bus.perf_fetch  = fetch_cnt;
  assign bus.perf_bubble = bubble_cnt;
  assign bus.perf_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage with an event-level reference model and directed scenarios.
module tb_if_id_stage;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  if_id_stage_if #(.DATA_W(16)) bus();

  if_id_stage #(.DATA_W(16), .NOP_INSTR(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = running, 1 = waiting for HLT to retire, 2 = halted
  int          mode;
  logic [15:0] e_instr, e_pc;
  logic        e_vld;
  int          n_fetch, n_bubble, n_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic model_reset();
    mode = 0; e_instr = NOP; e_pc = 16'h0000; e_vld = 1'b0;
    n_fetch = 0; n_bubble = 0; n_stall = 0;
  endtask

  task automatic model_edge();
    if (mode == 2) return;
    if (mode == 0 && bus.stall) n_stall++;
    if (mode == 1 && bus.hlt_retired) begin
      if (bus.flush || !bus.stall) n_bubble++;
      mode = 2; e_instr = NOP; e_vld = 1'b0;
    end else if (bus.flush) begin
      n_bubble++;
      mode = 0; e_instr = NOP; e_vld = 1'b0;
    end else if (bus.stall) begin
      // everything holds
    end else if (mode == 1) begin
      n_bubble++;
      e_instr = NOP; e_vld = 1'b0;
    end else begin
      n_fetch++;
      e_instr = bus.instr_in; e_pc = bus.pc_plus_1_in; e_vld = 1'b1;
      if (bus.instr_in[15:12] == 4'hF) mode = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".instr"}, bus.instr_out, e_instr);
    if (e_vld) check({tag, ".pc"}, bus.pc_plus_1_out, e_pc);
    check({tag, ".valid"}, bus.valid_out, e_vld);
    check({tag, ".hlt_fetch"}, bus.hlt_fetch, mode != 0);
    check({tag, ".halted"}, bus.halted, mode == 2);
`ifdef IF_ID_PERF_EN
    check({tag, ".perf_fetch"}, bus.perf_fetch, sat16(n_fetch));
    check({tag, ".perf_bubble"}, bus.perf_bubble, sat16(n_bubble));
    check({tag, ".perf_stall"}, bus.perf_stall, sat16(n_stall));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] p,
                       input logic s, input logic f, input logic h);
    bus.instr_in = i; bus.pc_plus_1_in = p;
    bus.stall = s; bus.flush = f; bus.hlt_retired = h;
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_hlt);
    logic [15:0] r;
    r = 16'($urandom);
    if (!allow_hlt && r[15:12] == 4'hF) r[15] = 1'b0;
    return r;
  endfunction

  // Reset asserted mid-cycle must clear outputs before the next rising edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_outputs("reset");
    check("reset.pc", bus.pc_plus_1_out, 16'h0000);
    @(negedge clk) rst = 1'b0;

    // Plain load
    drive(16'h1234, 16'h0005, 0, 0, 0);
    step("load");
    check("load.instr_const", bus.instr_out, 16'h1234);
    check("load.pc_const", bus.pc_plus_1_out, 16'h0005);

    // Stall holds while instr_in keeps changing
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(1), 16'($urandom), 1, 0, 0);
      step("stall");
    end
    check("stall.instr_const", bus.instr_out, 16'h1234);
    drive(16'h4321, 16'h0009, 1, 1, 0);
    step("flush_stall");
    check("flush_stall.valid_const", bus.valid_out, 1'b0);

    // hlt_retired in RUN is ignored
    drive(16'h2222, 16'h0006, 0, 0, 1);
    step("retire_in_run");

    // HLT load, two bubbles, retirement, then stuck halted
    drive(16'hF000, 16'h0010, 0, 0, 0);
    step("hlt_load");
    check("hlt_load.hlt_fetch_const", bus.hlt_fetch, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(rand_instr(1), 16'($urandom), 0, 0, 0);
      step("hlt_bubble");
    end
    drive(16'h3333, 16'h0011, 0, 0, 1);
    step("hlt_retire");
    check("hlt_retire.halted_const", bus.halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(rand_instr(1), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step("halted_hold");
    end
    check("halted_hold.halted_const", bus.halted, 1'b1);

    // Async reset while HALT_PEND is active
    async_reset("rst_halted");
    drive(16'hF000, 16'h0020, 0, 0, 0);
    step("pend_load");
    async_reset("rst_pend");
    check("rst_pend.hlt_fetch_const", bus.hlt_fetch, 1'b0);

    // Flush kills a pending HLT; normal loads resume
    drive(16'hF000, 16'h0030, 0, 0, 0);
    step("kill_load");
    drive(16'h5555, 16'h0031, 0, 1, 0);
    step("kill_flush");
    check("kill_flush.hlt_fetch_const", bus.hlt_fetch, 1'b0);
    drive(16'h6666, 16'h0032, 0, 0, 0);
    step("resume");
    check("resume.instr_const", bus.instr_out, 16'h6666);

    // Flush on the same edge as an HLT load wins
    drive(16'hF123, 16'h0040, 0, 1, 0);
    step("flush_vs_hlt");

    // pc_plus_1 wrap passes through
    drive(16'h0101, 16'h0000, 0, 0, 0);
    step("pc_wrap");

`ifdef IF_ID_PERF_EN
    async_reset("perf_rst");
    for (int i = 0; i < 5; i++) begin
      drive(rand_instr(0), 16'(i), 0, 0, 0);
      step("perf_load");
    end
    for (int i = 0; i < 2; i++) begin
      drive(rand_instr(0), 16'h0, 0, 1, 0);
      step("perf_flush");
    end
    for (int i = 0; i < 3; i++) begin
      drive(rand_instr(0), 16'h0, 1, 0, 0);
      step("perf_stall");
    end
    check("perf.fetch5", bus.perf_fetch, 16'd5);
    check("perf.bubble2", bus.perf_bubble, 16'd2);
    check("perf.stall3", bus.perf_stall, 16'd3);
    for (int i = 0; i < 70000; i++) begin
      drive(rand_instr(0), 16'(i), 0, 0, 0);
      @(posedge clk);
      model_edge();
      #1;
    end
    check_outputs("perf_sat");
    check("perf_sat.fetch_const", bus.perf_fetch, 16'hFFFF);
`endif

    // Randomized traffic against the model
    begin
      int halted_cycles = 0;
      for (int i = 0; i < 600; i++) begin
        drive(rand_instr($urandom_range(7) == 0), 16'($urandom),
              $urandom_range(4) == 0, $urandom_range(7) == 0,
              (mode == 1) && ($urandom_range(3) == 0));
        step("rand");
        halted_cycles = (mode == 2) ? halted_cycles + 1 : 0;
        if (halted_cycles > 8) begin
          async_reset("rand_rst");
          halted_cycles = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
